// File: rtl/core_run_monitor.sv
// Run controller and health monitor for NUM_CH debug-traced cores.
// Optional periodic log strobe is enabled by defining RUN_MON_LOG_EN.
module core_run_monitor #(
  parameter int NUM_CH     = 1,
  parameter int ADDR_W     = 32,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 2000,
  parameter int HALT_CYC   = 4,
  parameter logic [XLEN-1:0] PASS_VAL = 1,
  parameter int LOG_PERIOD = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*ADDR_W-1:0] pc_in,
  input  logic [NUM_CH*XLEN-1:0]   x1_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [2:0]               fail_ch,
  output logic [NUM_CH-1:0]        halted,
  output logic [CNT_W-1:0]         cycles,
  output logic                     log_stb
);

  localparam int SW = $clog2(HALT_CYC + 1);
  localparam logic [SW-1:0] HMAX = SW'(HALT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              armed_q;
  logic              go;
  logic              term;
  logic [1:0]        code_d;
  logic [2:0]        ch_d;
  logic              pass_d;
  logic [2:0]        mis_ch;
  logic [2:0]        bad_ch;

  logic [ADDR_W-1:0] pc_c       [NUM_CH];
  logic [XLEN-1:0]   x1_c       [NUM_CH];
  logic [ADDR_W-1:0] prev_pc_q  [NUM_CH];
  logic [XLEN-1:0]   x1_q       [NUM_CH];
  logic [SW-1:0]     stall_q    [NUM_CH];
  logic [SW-1:0]     stall_d    [NUM_CH];

  logic [NUM_CH-1:0] prev_valid_q;
  logic [NUM_CH-1:0] halted_q;
  logic [NUM_CH-1:0] halted_d;
  logic [NUM_CH-1:0] halt_now;
  logic [NUM_CH-1:0] mis;
  logic [NUM_CH-1:0] bad_x1;

  logic [CNT_W-1:0]  cycles_q;
  logic [1:0]        fail_code_q;
  logic [2:0]        fail_ch_q;
  logic              pass_q;

  // start is only honoured once a clock edge has passed since reset release
  assign go = start && armed_q;

  always_comb begin
    mis_ch = '0;
    bad_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pc_c[i]  = pc_in[i*ADDR_W +: ADDR_W];
      x1_c[i]  = x1_in[i*XLEN +: XLEN];
      stall_d[i] = '0;
      if (prev_valid_q[i] && pc_c[i] == prev_pc_q[i])
        stall_d[i] = (stall_q[i] == HMAX) ? HMAX : stall_q[i] + 1'b1;
      halt_now[i] = (stall_d[i] == HMAX);
      mis[i]      = (pc_c[i][1:0] != 2'b00);
      bad_x1[i]   = (halted_q[i] ? x1_q[i] : x1_c[i]) != PASS_VAL;
    end
    halted_d = halted_q | halt_now;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mis[i])    mis_ch = 3'(i);
      if (bad_x1[i]) bad_ch = 3'(i);
    end
  end

  always_comb begin
    term   = 1'b0;
    code_d = 2'd0;
    ch_d   = '0;
    pass_d = 1'b0;
    if (|mis) begin
      term   = 1'b1;
      code_d = 2'd1;
      ch_d   = mis_ch;
    end else if (&halted_d) begin
      term = 1'b1;
      if (|bad_x1) begin
        code_d = 2'd2;
        ch_d   = bad_ch;
      end else begin
        pass_d = 1'b1;
      end
    end else if (cycles_q == LAST) begin
      term   = 1'b1;
      code_d = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go)   state_d = S_RUN;
      S_RUN:   if (term) state_d = S_DONE;
      S_DONE:  if (go)   state_d = S_RUN;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q     <= '0;
      prev_valid_q <= '0;
      halted_q     <= '0;
      fail_code_q  <= '0;
      fail_ch_q    <= '0;
      pass_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_pc_q[i] <= '0;
        x1_q[i]      <= '0;
        stall_q[i]   <= '0;
      end
    end else if (state_q != S_RUN && go) begin
      cycles_q     <= '0;
      prev_valid_q <= '0;
      halted_q     <= '0;
      fail_code_q  <= '0;
      fail_ch_q    <= '0;
      pass_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        stall_q[i] <= '0;
    end else if (state_q == S_RUN) begin
      if (cycles_q != '1)
        cycles_q <= cycles_q + 1'b1;
      prev_valid_q <= '1;
      halted_q     <= halted_d;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_pc_q[i] <= pc_c[i];
        stall_q[i]   <= stall_d[i];
        if (halt_now[i] && !halted_q[i])
          x1_q[i] <= x1_c[i];
      end
      if (term) begin
        fail_code_q <= code_d;
        fail_ch_q   <= ch_d;
        pass_q      <= pass_d;
      end
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign fail_ch   = fail_ch_q;
  assign halted    = halted_q;
  assign cycles    = cycles_q;

`ifdef RUN_MON_LOG_EN
  localparam int LW = $clog2(LOG_PERIOD + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOG_PERIOD - 1);

  // Tracks cycles % LOG_PERIOD without a divider
  logic [LW-1:0] log_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      log_cnt_q <= '0;
    else if (state_q != S_RUN && go)
      log_cnt_q <= '0;
    else if (state_q == S_RUN)
      log_cnt_q <= (log_cnt_q == LMAX) ? '0 : log_cnt_q + 1'b1;
  end

  assign log_stb = (state_q == S_RUN) && (log_cnt_q == '0);

`ifdef SIM
  always_ff @(posedge clk) begin
    if (log_stb) begin
      $display("[%0t] run_mon cycles=%0d", $time, cycles_q);
      for (int i = 0; i < NUM_CH; i++)
        $display("  ch%0d pc=%h x1=%h", i, pc_c[i], x1_c[i]);
    end
  end
`endif
`else
  logic unused_log;
  assign unused_log = (LOG_PERIOD == 0);
  assign log_stb    = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor (two channels, short budget).
// Expected verdicts are queued at stimulus time and popped at done.
module tb_core_run_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] pc_in;
  logic [63:0] x1_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [2:0]  fail_ch;
  logic [1:0]  halted;
  logic [31:0] cycles;
  logic        log_stb;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [1:0]  code;
    logic [2:0]  ch;
    logic        pass;
    logic [1:0]  halted;
    logic [31:0] cycles;
  } exp_t;

  exp_t sb[$];

  core_run_monitor #(
    .NUM_CH(2), .ADDR_W(32), .XLEN(32), .CNT_W(32),
    .MAX_CYCLES(20), .HALT_CYC(4), .PASS_VAL(32'd1),
    .LOG_PERIOD(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pc_in(pc_in), .x1_in(x1_in),
    .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_ch(fail_ch),
    .halted(halted), .cycles(cycles), .log_stb(log_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_of(int m, int ch, int c);
    case (m)
      0: return (c == 0) ? 32'h0 : (c == 1) ? 32'h4 : 32'h8;
      1: return (ch == 0) ? 32'h100 : (c < 10) ? 32'(c * 4) : 32'h40;
      2: return (ch == 1) ? 32'h200 : (c == 4) ? 32'h6 : 32'(c * 4);
      3: return 32'(c * 4 + ch * 'h1000);
      4: return (ch == 0) ? 32'(c * 4) :
                (c == 2) ? 32'h202 : 32'(c * 4 + 'h1000);
      5: return 32'h80;
      6: return (ch == 0) ? 32'h100 :
                (c < 6) ? 32'(c * 4 + 'h1000) : 32'h2000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] x1_of(int m, int ch, int c);
    case (m)
      1: return (ch == 1) ? 32'd5 : 32'd1;
      6: return (ch == 0 && c > 4) ? 32'd9 : 32'd1;
      default: return 32'd1;
    endcase
  endfunction

  task automatic drive(input int m, input int c);
    for (int ch = 0; ch < 2; ch++) begin
      pc_in[ch*32 +: 32] = pc_of(m, ch, c);
      x1_in[ch*32 +: 32] = x1_of(m, ch, c);
    end
  endtask

  task automatic push(input logic [1:0] code, input logic [2:0] ch,
                      input logic p, input logic [1:0] h,
                      input logic [31:0] cyc);
    exp_t e;
    e.code = code; e.ch = ch; e.pass = p;
    e.halted = h; e.cycles = cyc;
    sb.push_back(e);
  endtask

  task automatic finish_run(input int m, input int c0);
    exp_t e;
    int c;
    int logs;
    c = c0;
    logs = 0;
    while (!done && c < 60) begin
      drive(m, c);
      if (m == 3) start = (c >= 8 && c < 11);
      if (log_stb) logs++;
      tick();
      c++;
    end
    start = 1'b0;
    chk("done", done, 1'b1);
    chk("busy_off", busy, 1'b0);
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk("fail_code", fail_code, e.code);
      chk("fail_ch", fail_ch, e.ch);
      chk("pass", pass, e.pass);
      chk("halted", halted, e.halted);
      chk("cycles", cycles, e.cycles);
    end
`ifdef RUN_MON_LOG_EN
    if (m == 3) chk("log_cnt", logs, 4);
`else
    if (m == 3) chk("log_cnt", logs, 0);
`endif
  endtask

  task automatic run_mode(input int m);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", busy, 1'b1);
    chk("cyc_clr", cycles, 0);
    chk("halt_clr", halted, 2'b00);
    finish_run(m, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_code"}, fail_code, 2'd0);
    chk({tag, "_ch"}, fail_ch, 3'd0);
    chk({tag, "_halted"}, halted, 2'b00);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_log"}, log_stb, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    pc_in = '0;
    x1_in = '0;
    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    start = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("start_at_release", busy, 1'b0);
    start = 1'b0;
    tick();

    push(2'd0, 3'd0, 1'b1, 2'b11, 32'd7);
    run_mode(0);
    push(2'd2, 3'd1, 1'b0, 2'b11, 32'd15);
    run_mode(1);
    push(2'd1, 3'd0, 1'b0, 2'b10, 32'd5);
    run_mode(2);
    push(2'd3, 3'd0, 1'b0, 2'b00, 32'd20);
    run_mode(3);
    push(2'd1, 3'd1, 1'b0, 2'b00, 32'd3);
    run_mode(4);
    push(2'd0, 3'd0, 1'b1, 2'b11, 32'd11);
    run_mode(6);
    push(2'd0, 3'd0, 1'b1, 2'b11, 32'd5);
    run_mode(5);

    start = 1'b1;
    tick();
    chk("hold_busy0", busy, 1'b1);
    chk("hold_cyc0", cycles, 0);
    chk("hold_pass_clr", pass, 1'b0);
    tick();
    chk("hold_busy1", busy, 1'b1);
    chk("hold_cyc1", cycles, 1);
    start = 1'b0;
    push(2'd0, 3'd0, 1'b1, 2'b11, 32'd5);
    finish_run(5, 2);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1, c);
      tick();
    end
    chk("mid_cycles", cycles, 6);
    chk("mid_halted", halted, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    rst_n = 1'b1;
    tick();
    push(2'd2, 3'd1, 1'b0, 2'b11, 32'd15);
    run_mode(1);

    if (sb.size() != 0) chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
